// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the 32-bit machine word and the RAM status encoding
// reported by the memory model back to the arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction fetch and data paths.
// One access is in flight at a time. The address, store data and read/write
// type are captured when IDLE is left, so the RAM sees stable values even if
// the requester changes its inputs mid-access. Hits are pulsed combinationally
// in the cycle the RAM reports ACCESS. A hit is suppressed if the requester
// has dropped its request by then. A RAM ERROR or a wait longer than TIMEOUT
// cycles parks the arbiter in FAULT until nRST.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DACC  = 2'd1,
        IACC  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // The last wait value before the counter reaches TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_s;
    word_t      addr_r;
    word_t      addr_s;
    word_t      store_r;
    word_t      store_s;
    logic       wr_r;
    logic       wr_s;
    logic [7:0] wait_r;
    logic [7:0] wait_s;
    logic       last_d_r;
    logic       last_d_s;
    logic       data_req_s;

    assign data_req_s = dREN | dWEN;

    // State, captured request and wait counter registers; async reset clears all.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= IDLE;
            addr_r   <= WORD_ZERO;
            store_r  <= WORD_ZERO;
            wr_r     <= 1'b0;
            wait_r   <= 8'd0;
            last_d_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            store_r  <= store_s;
            wr_r     <= wr_s;
            wait_r   <= wait_s;
            last_d_r <= last_d_s;
        end
    end

    // Next-state logic: arbitration, request capture, completion and fault detection.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        store_s  = store_r;
        wr_s     = wr_r;
        wait_s   = wait_r;
        last_d_s = last_d_r;
        case (state_r)
            IDLE: begin
                // Data wins unless the previous completed access was data and
                // an instruction fetch is also waiting.
                if (data_req_s && !(iREN && last_d_r)) begin
                    state_s = DACC;
                    addr_s  = daddr;
                    store_s = dstore;
                    wr_s    = dWEN;
                    wait_s  = 8'd0;
                end else if (iREN) begin
                    state_s = IACC;
                    addr_s  = iaddr;
                    store_s = dstore;
                    wr_s    = 1'b0;
                    wait_s  = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            DACC, IACC: begin
                if (ramstate == ACCESS) begin
                    state_s  = IDLE;
                    last_d_s = (state_r == DACC);
                end else if (ramstate == ERROR) begin
                    state_s = FAULT;
                end else if (wait_r == WAIT_LAST) begin
                    state_s = FAULT;
                    wait_s  = wait_r + 8'd1;
                end else begin
                    wait_s = wait_r + 8'd1;
                end
            end
            FAULT: begin
                state_s = FAULT;
            end
            default: begin
                state_s = FAULT;
            end
        endcase
    end

    // Output decode: RAM strobes from captured registers, hits and load data on ACCESS.
    always_comb begin
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = WORD_ZERO;
        dload    = WORD_ZERO;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = WORD_ZERO;
        ramstore = WORD_ZERO;
        memerr   = 1'b0;
        case (state_r)
            IDLE: begin
                memerr = 1'b0;
            end
            DACC: begin
                ramaddr  = addr_r;
                ramstore = store_r;
                ramWEN   = wr_r;
                ramREN   = !wr_r;
                if (ramstate == ACCESS) begin
                    dhit  = wr_r ? dWEN : dREN;
                    dload = (!wr_r && dREN) ? ramload : WORD_ZERO;
                end else begin
                    dhit  = 1'b0;
                end
            end
            IACC: begin
                ramaddr = addr_r;
                ramREN  = 1'b1;
                if ((ramstate == ACCESS) && iREN) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end else begin
                    ihit  = 1'b0;
                end
            end
            FAULT: begin
                memerr = 1'b1;
            end
            default: begin
                memerr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 16;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding transaction or none, plus sticky fault.
    bit    m_busy, m_isd, m_wr, m_last_d, m_fault;
    word_t m_addr, m_store;
    int    m_wait;

    // Scenario observation counters.
    int         cnt_rren, cnt_rwen, cnt_ih, cnt_dh;
    logic [7:0] gseq;
    word_t      last_il, last_dl, last_rstore;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_isd = 0; m_wr = 0; m_last_d = 0; m_fault = 0;
        m_addr = '0; m_store = '0; m_wait = 0;
    endtask

    task automatic clear_counts();
        cnt_rren = 0; cnt_rwen = 0; cnt_ih = 0; cnt_dh = 0; gseq = 8'd0;
        last_il = '0; last_dl = '0; last_rstore = '0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model to reflect the following rising edge.
    task automatic cycle(input logic ir, input logic dr, input logic dw,
                         input word_t ia, input word_t da, input word_t ds,
                         input ramstate_t rs, input word_t rl);
        logic  e_ih, e_dh, e_rr, e_rw;
        word_t e_il, e_dl, e_ra, e_rs;
        bit    acc;
        @(negedge CLK);
        iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        #1;
        acc  = (rs == ACCESS);
        e_ih = 0; e_dh = 0; e_rr = 0; e_rw = 0;
        e_il = '0; e_dl = '0; e_ra = '0; e_rs = '0;
        if (!m_fault && m_busy) begin
            e_ra = m_addr;
            if (m_isd) begin
                e_rs = m_store;
                e_rw = m_wr;
                e_rr = !m_wr;
                e_dh = acc && (m_wr ? dw : dr);
                e_dl = (acc && !m_wr && dr) ? rl : 32'h0;
            end else begin
                e_rr = 1'b1;
                e_ih = acc && ir;
                e_il = e_ih ? rl : 32'h0;
            end
        end
        chk("ctl", {27'd0, ihit, dhit, ramREN, ramWEN, memerr},
                   {27'd0, e_ih, e_dh, e_rr, e_rw, m_fault});
        chk("iload", iload, e_il);
        chk("dload", dload, e_dl);
        chk("ramaddr", ramaddr, e_ra);
        chk("ramstore", ramstore, e_rs);
        chk("excl", {31'd0, (ihit & dhit) | (ramREN & ramWEN)}, 32'd0);

        if (ramREN) cnt_rren++;
        if (ramWEN) begin cnt_rwen++; last_rstore = ramstore; end
        if (ihit) begin cnt_ih++; last_il = iload; gseq = {gseq[6:0], 1'b0}; end
        if (dhit) begin cnt_dh++; last_dl = dload; gseq = {gseq[6:0], 1'b1}; end

        if (!m_fault) begin
            if (!m_busy) begin
                if ((dr || dw) && !(ir && m_last_d)) begin
                    m_busy = 1; m_isd = 1; m_wr = dw; m_addr = da; m_store = ds; m_wait = 0;
                end else if (ir) begin
                    m_busy = 1; m_isd = 0; m_wr = 0; m_addr = ia; m_store = ds; m_wait = 0;
                end
            end else begin
                if (rs == ACCESS) begin
                    m_busy = 0; m_last_d = m_isd;
                end else if (rs == ERROR) begin
                    m_fault = 1;
                end else begin
                    m_wait++;
                    if (m_wait >= TO) m_fault = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, '0, '0, FREE, '0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
    task automatic pulse_reset();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_ctl", {27'd0, ihit, dhit, ramREN, ramWEN, memerr}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_loads", iload | dload, 32'd0);
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
        model_reset();
        clear_counts();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    function automatic ramstate_t rand_rs();
        int r;
        r = $urandom_range(0, 999);
        if (r < 400)      return ACCESS;
        else if (r < 850) return BUSY;
        else if (r < 995) return FREE;
        else              return ERROR;
    endfunction

    initial begin
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        model_reset();
        clear_counts();
        repeat (2) @(negedge CLK);
        #1;
        chk("por_ctl", {27'd0, ihit, dhit, ramREN, ramWEN, memerr}, 32'd0);
        chk("por_ramaddr", ramaddr, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        idle(2);

        // Instruction fetch with ACCESS one cycle after the request.
        pulse_reset();
        cycle(1, 0, 0, 32'h0000_0040, '0, '0, FREE, '0);
        cycle(1, 0, 0, 32'h0000_0040, '0, '0, ACCESS, 32'h2408_0005);
        idle(2);
        chk("s37_ihits", cnt_ih, 1);
        chk("s37_iload", last_il, 32'h2408_0005);
        chk("s37_ren_cycles", cnt_rren, 1);

        // Data write with three BUSY cycles then ACCESS.
        pulse_reset();
        cycle(0, 0, 1, '0, 32'h80, 32'hDEAD_BEEF, FREE, '0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, '0, 32'h80, 32'hDEAD_BEEF, BUSY, '0);
        cycle(0, 0, 1, '0, 32'h80, 32'hDEAD_BEEF, ACCESS, 32'h1234_5678);
        idle(2);
        chk("s38_wen_cycles", cnt_rwen, 4);
        chk("s38_ramstore", last_rstore, 32'hDEAD_BEEF);
        chk("s38_dhits", cnt_dh, 1);

        // Both requesters held continuously: alternating grants.
        pulse_reset();
        for (int k = 0; k < 8; k++)
            cycle(1, 1, 0, 32'h100 + 32'(k), 32'h200 + 32'(k), '0, ACCESS, 32'hA000_0000 + 32'(k));
        idle(1);
        chk("s39_order", {28'd0, gseq[3:0]}, {28'd0, 4'b1010});
        chk("s39_hits", cnt_ih + cnt_dh, 4);

        // Fetch stuck on BUSY: fault after exactly TO wait cycles.
        pulse_reset();
        cycle(1, 0, 0, 32'h44, '0, '0, BUSY, '0);
        for (int k = 0; k < TO; k++) cycle(1, 0, 0, 32'h44, '0, '0, BUSY, '0);
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 32'h44, '0, '0, ACCESS, 32'h5);
        chk("s40_memerr", {31'd0, memerr}, 32'd1);
        chk("s40_no_ihit", cnt_ih, 0);

        // Reset in the middle of a busy data read, then a fresh read.
        pulse_reset();
        cycle(0, 1, 0, '0, 32'h90, '0, FREE, '0);
        cycle(0, 1, 0, '0, 32'h90, '0, BUSY, '0);
        pulse_reset();
        cycle(0, 1, 0, '0, 32'h100, '0, FREE, '0);
        cycle(0, 1, 0, '0, 32'h100, '0, ACCESS, 32'hCAFE_F00D);
        idle(1);
        chk("s41_dhits", cnt_dh, 1);
        chk("s41_dload", last_dl, 32'hCAFE_F00D);

        // Data read request withdrawn before ACCESS: access completes silently.
        pulse_reset();
        cycle(0, 1, 0, '0, 32'h300, '0, FREE, '0);
        cycle(0, 0, 0, '0, 32'h300, '0, BUSY, '0);
        cycle(0, 0, 0, '0, 32'h300, '0, ACCESS, 32'h7777_0000);
        idle(2);
        chk("s42_ren_cycles", cnt_rren, 2);
        chk("s42_no_dhit", cnt_dh, 0);

        // Randomized traffic, each block starting from reset.
        for (int b = 0; b < 6; b++) begin
            pulse_reset();
            for (int k = 0; k < 150; k++)
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), word_t'($urandom), word_t'($urandom),
                      word_t'($urandom), rand_rs(), word_t'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles an access may wait for ramstate ACCESS before error (range 2..255).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: iREN  input  1  instruction read request.
REQ-005 SHALL have port: iaddr  input  32  instruction address.
REQ-006 SHALL have port: dREN  input  1  data read request.
REQ-007 SHALL have port: dWEN  input  1  data write request.
REQ-008 SHALL have port: daddr  input  32  data address.
REQ-009 SHALL have port: dstore  input  32  data write value.
REQ-010 SHALL have port: ihit  output  1  one-cycle instruction completion pulse, consumed by the hazard unit.
REQ-011 SHALL have port: dhit  output  1  one-cycle data completion pulse, consumed by the hazard unit.
REQ-012 SHALL have port: iload  output  32  instruction word, valid while ihit=1.
REQ-013 SHALL have port: dload  output  32  data read word, valid while dhit=1 on a read.
REQ-014 SHALL have ports: ramREN, ramWEN  output  1 each  RAM strobes.
REQ-015 SHALL have ports: ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 SHALL have port: ramload  input  32  RAM read data.
REQ-017 SHALL have port: ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-018 SHALL have port: memerr  output  1  sticky fault flag.

Function
REQ-019 SHALL implement FSM states IDLE, DACC, IACC, FAULT.
REQ-020 IDLE: RAM strobes 0; if dREN|dWEN go to DACC, else if iREN go to IACC, else stay.
REQ-021 If both request types are pending in IDLE and the previous completed access was DACC, SHALL go to IACC; otherwise data has priority.
REQ-022 On leaving IDLE, SHALL register address, dstore and the read/write type; RAM outputs come from these registers only.
REQ-023 DACC: ramaddr=captured daddr; ramWEN=1 for a write, else ramREN=1; ramstore=captured dstore.
REQ-024 IACC: ramaddr=captured iaddr, ramREN=1, ramWEN=0.
REQ-025 In DACC or IACC with ramstate==ACCESS, SHALL pulse dhit or ihit combinationally that cycle, drive dload or iload=ramload, and return to IDLE.
REQ-026 If the request is deasserted before ACCESS, the RAM access SHALL still complete, but the hit SHALL be suppressed.
REQ-027 SHALL never assert ihit and dhit in the same cycle, and never assert ramREN and ramWEN together.
REQ-028 Minimum latency: request at cycle N with ramstate==ACCESS at N+1 gives hit at N+1; back-to-back accesses have one IDLE cycle between them.
REQ-029 An 8-bit wait counter SHALL clear on entering DACC/IACC and increment each non-ACCESS cycle; reaching TIMEOUT goes to FAULT.
REQ-030 ramstate==ERROR in DACC or IACC SHALL go to FAULT immediately.
REQ-031 FAULT: memerr=1; strobes, ihit and dhit 0; request inputs ignored; exit only via nRST.
REQ-032 iload and dload SHALL read 0 when the corresponding hit is 0.

Reset
REQ-033 nRST low SHALL immediately force state IDLE, captured registers 0, wait counter 0, last-grant=instruction, memerr 0, and all outputs 0.
REQ-034 Reset asserted mid-access SHALL abort the access with no hit; the first request after release is arbitrated afresh.

Structure
REQ-035 ramstate_t and the word_t 32-bit type SHALL reside in cpu_types_pkg; the FSM state enum SHALL be local to the module.
REQ-036 SHALL be a single module with no sub-modules; the parameter default SHALL be overridable at instantiation.

Verification
REQ-037 Scenario: iREN=1, iaddr=0x0000_0040, ramstate ACCESS one cycle after the request, ramload=0x2408_0005 -> ihit pulses once with iload=0x2408_0005; ramREN high for exactly 1 cycle.
REQ-038 Scenario: dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN high for 4 cycles, ramstore=0xDEAD_BEEF, dhit on the 4th cycle.
REQ-039 Scenario: iREN and dREN held together continuously -> grant order D, I, D, I, with no simultaneous ihit and dhit.
REQ-040 Scenario: iREN=1 with ramstate BUSY forever, TIMEOUT=16 -> FAULT after 16 wait cycles, memerr=1 stuck, no ihit until nRST.
REQ-041 Scenario: nRST pulsed low during DACC with ramstate BUSY -> all outputs 0 immediately, no dhit; a new dREN after release is served normally.
REQ-042 Scenario: dREN dropped after 1 cycle with ACCESS at cycle 3 -> ramREN completes to cycle 3, dhit stays 0, FSM returns to IDLE.
